// File: rtl/sweeper_pkg.sv
// sweeper_pkg
// Shared types and constants for the minterm sweeper slice: the sweep FSM
// state encoding, the number of minterms visited for a 4-input function,
// and the width of the minterm index register.
package sweeper_pkg;

    // Sweep FSM states: waiting for start, holding a minterm, sweep finished.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // A 4-input function has 16 minterms; the index register covers them all.
    localparam int N_PATTERNS = 16;
    localparam int IDX_W      = 4;

    // The population count must reach 16, so it needs one bit more than IDX_W.
    localparam int ONES_W     = 5;

endpackage

// File: rtl/minterm_sweeper_hold_timer.sv
// hold_timer
// Counts the cycles a minterm has been held. While en is high the counter
// advances each cycle; expire is high during the last cycle of a hold, so
// the edge that ends the hold is the edge that samples the function output.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   en      in   count while high (the sweeper is in its HOLD state)
//   expire  out  high on the final cycle of each HOLD_CYCLES-long hold
module hold_timer #(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expire
);

    localparam int                 CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;

    assign expire = en && (hcnt_q == LAST);

    // The counter wraps to zero on every expiry, and a sweep always ends
    // on an expiry, so it is already zero whenever a new sweep starts and
    // needs no separate clear from the FSM.
    always_comb begin
        hcnt_d = hcnt_q;
        if (en) begin
            hcnt_d = expire ? '0 : hcnt_q + CNT_W'(1);
        end
    end

    // Counter register; reset also covers a sweep aborted mid-hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end

endmodule

// File: rtl/minterm_sweeper.sv
// minterm_sweeper
// Drives a 4-input combinational block through all 16 minterms in ascending
// order, holding each for HOLD_CYCLES cycles, and captures the block output
// at the end of each hold into a truth-table word plus a population count.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begins a sweep when sampled in IDLE or DONE
//   f_in         in   output of the function under test
//   a, b, c, d   out  minterm index {a,b,c,d}, a is the MSB
//   busy         out  high while a sweep is in progress
//   done         out  high from sweep completion until next start or reset
//   truth[15:0]  out  truth[m] is f_in as sampled for minterm m
//   ones[4:0]    out  number of set bits in truth
module minterm_sweeper
    import sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  f_in,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  busy,
    output logic                  done,
    output logic [N_PATTERNS-1:0] truth,
    output logic [ONES_W-1:0]     ones
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PATTERNS - 1);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N_PATTERNS-1:0]   truth_q;
    logic [N_PATTERNS-1:0]   truth_d;
    logic [ONES_W-1:0]       ones_q;
    logic [ONES_W-1:0]       ones_d;
    logic                    busy_q;
    logic                    done_q;
    logic                    timerEn;
    logic                    expire;

    assign timerEn = (state_q == HOLD);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (timerEn),
        .expire (expire)
    );

    // Values the capture registers take if the current hold ends this cycle:
    // the current minterm's bit is replaced by f_in and the count bumped.
    always_comb begin
        truth_d         = truth_q;
        truth_d[idx_q]  = f_in;
        ones_d          = ones_q + ONES_W'(f_in);
    end

    // Sweep FSM. start is only looked at outside HOLD, so pulses during a
    // sweep are ignored, and a start held high restarts from DONE on the
    // edge after DONE is entered. f_in is only consumed on the expiry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            truth_q <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= HOLD;
                        idx_q   <= '0;
                        truth_q <= '0;
                        ones_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (expire) begin
                        truth_q <= truth_d;
                        ones_q  <= ones_d;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth        = truth_q;
    assign ones         = ones_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper
// Table-driven check of minterm_sweeper with HOLD_CYCLES=4, plus hand-written
// sequences for ignored start, restart from DONE, mid-sweep reset and an
// HOLD_CYCLES=1 instance whose f_in glitches only between sample edges.
module tb_minterm_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4;
    logic        start1;
    logic        f4;
    logic        f1;

    logic        a4, b4, c4, d4, busy4, done4;
    logic [15:0] truth4;
    logic [4:0]  ones4;

    logic        a1, b1, c1, d1, busy1, done1;
    logic [15:0] truth1;
    logic [4:0]  ones1;

    int          checks   = 0;
    int          failures = 0;
    int          mode4;
    logic        glitchMode;
    logic        glitchPulse;
    int          cnt;

    typedef struct {
        int          mode;
        logic [15:0] expTruth;
        logic [4:0]  expOnes;
    } vec_t;

    vec_t vecs [4];

    minterm_sweeper #(.HOLD_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .f_in  (f4),
        .a     (a4),
        .b     (b4),
        .c     (c4),
        .d     (d4),
        .busy  (busy4),
        .done  (done4),
        .truth (truth4),
        .ones  (ones4)
    );

    minterm_sweeper #(.HOLD_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .f_in  (f1),
        .a     (a1),
        .b     (b1),
        .c     (c1),
        .d     (d1),
        .busy  (busy1),
        .done  (done1),
        .truth (truth1),
        .ones  (ones1)
    );

    always #5 clk = ~clk;

    // Function under test for the H=4 instance: mode 0 is (A&B)|(C&~D),
    // 1 is constant 0, 2 is constant 1, 3 passes D straight through.
    always_comb begin
        f4 = 1'b0;
        case (mode4)
            0:       f4 = (a4 & b4) | (c4 & ~d4);
            1:       f4 = 1'b0;
            2:       f4 = 1'b1;
            default: f4 = d4;
        endcase
    end

    // Function under test for the H=1 instance: either the same logic
    // function or a pulse that is only high between sampling edges.
    always_comb begin
        f1 = glitchMode ? glitchPulse : ((a1 & b1) | (c1 & ~d1));
    end

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every output of the H=4 instance against its reset value.
    task automatic checkIdle4(input string tag);
        checkOutput({tag, "_abcd4"},  32'({a4, b4, c4, d4}), 32'd0);
        checkOutput({tag, "_busy4"},  32'(busy4),  32'd0);
        checkOutput({tag, "_done4"},  32'(done4),  32'd0);
        checkOutput({tag, "_truth4"}, 32'(truth4), 32'd0);
        checkOutput({tag, "_ones4"},  32'(ones4),  32'd0);
    endtask

    // Start a sweep on the H=4 instance and count busy cycles until it ends.
    // When pulseAt >= 0, start is raised again for one edge at that cycle
    // offset from the start edge, after confirming minterm 5 is driven.
    task automatic applyStimulus(input int pulseAt, output int busyCnt);
        int cyc;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        checkOutput("start_busy", 32'(busy4), 32'd1);
        checkOutput("start_done", 32'(done4), 32'd0);
        checkOutput("start_abcd", 32'({a4, b4, c4, d4}), 32'd0);
        busyCnt = busy4 ? 1 : 0;
        cyc     = 0;
        while (busy4 && cyc < 500) begin
            if (cyc == pulseAt) begin
                checkOutput("mid_abcd", 32'({a4, b4, c4, d4}), 32'd5);
                start4 = 1'b1;
            end
            tick();
            start4 = 1'b0;
            cyc++;
            if (busy4) busyCnt++;
        end
        checkOutput("sweep_end_busy", 32'(busy4), 32'd0);
        checkOutput("sweep_end_done", 32'(done4), 32'd1);
    endtask

    // Start a sweep on the H=1 instance and count busy cycles. In glitch
    // mode f_in is raised 1 unit after each edge and dropped 3 units later.
    task automatic sweep1(output int busyCnt);
        int cyc;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        busyCnt = busy1 ? 1 : 0;
        cyc     = 0;
        while (busy1 && cyc < 100) begin
            glitchPulse = 1'b1;
            #3;
            glitchPulse = 1'b0;
            tick();
            cyc++;
            if (busy1) busyCnt++;
        end
        checkOutput("h1_end_done", 32'(done1), 32'd1);
    endtask

    initial begin
        vecs[0] = '{mode: 0, expTruth: 16'hF444, expOnes: 5'd7};
        vecs[1] = '{mode: 1, expTruth: 16'h0000, expOnes: 5'd0};
        vecs[2] = '{mode: 2, expTruth: 16'hFFFF, expOnes: 5'd16};
        vecs[3] = '{mode: 3, expTruth: 16'hAAAA, expOnes: 5'd8};

        rst         = 1'b1;
        start4      = 1'b1;
        start1      = 1'b1;
        mode4       = 0;
        glitchMode  = 1'b0;
        glitchPulse = 1'b0;

        // Reset held two cycles with start high: reset must win.
        tick();
        tick();
        checkIdle4("rst");
        checkOutput("rst_busy1", 32'(busy1), 32'd0);
        checkOutput("rst_done1", 32'(done1), 32'd0);
        rst    = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        tick();
        checkIdle4("post_rst");

        // Table of functions swept on the H=4 instance.
        for (int i = 0; i < 4; i++) begin
            mode4 = vecs[i].mode;
            applyStimulus(-1, cnt);
            checkOutput($sformatf("vec%0d_busycnt", i), 32'(cnt), 32'd64);
            checkOutput($sformatf("vec%0d_truth", i), 32'(truth4),
                        32'(vecs[i].expTruth));
            checkOutput($sformatf("vec%0d_ones", i), 32'(ones4),
                        32'(vecs[i].expOnes));
        end

        // start pulsed during minterm 5 is ignored; then restart from DONE.
        mode4 = 0;
        applyStimulus(21, cnt);
        checkOutput("ignored_start_busycnt", 32'(cnt), 32'd64);
        checkOutput("ignored_start_truth", 32'(truth4), 32'hF444);
        applyStimulus(-1, cnt);
        checkOutput("restart_busycnt", 32'(cnt), 32'd64);
        checkOutput("restart_truth", 32'(truth4), 32'hF444);
        checkOutput("restart_ones", 32'(ones4), 32'd7);

        // Reset while minterm 7 is driven aborts the sweep entirely.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (29) tick();
        checkOutput("pre_abort_abcd", 32'({a4, b4, c4, d4}), 32'd7);
        checkOutput("pre_abort_truth", 32'(truth4), 32'h0044);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle4("abort");
        tick();
        checkOutput("abort_stays_idle", 32'(busy4), 32'd0);
        applyStimulus(-1, cnt);
        checkOutput("after_abort_busycnt", 32'(cnt), 32'd64);
        checkOutput("after_abort_truth", 32'(truth4), 32'hF444);
        checkOutput("after_abort_ones", 32'(ones4), 32'd7);

        // H=1: normal capture, then glitches between sample edges only.
        glitchMode = 1'b0;
        sweep1(cnt);
        checkOutput("h1_busycnt", 32'(cnt), 32'd16);
        checkOutput("h1_truth", 32'(truth1), 32'hF444);
        checkOutput("h1_ones", 32'(ones1), 32'd7);
        glitchMode = 1'b1;
        sweep1(cnt);
        checkOutput("h1_glitch_busycnt", 32'(cnt), 32'd16);
        checkOutput("h1_glitch_truth", 32'(truth1), 32'h0000);
        checkOutput("h1_glitch_ones", 32'(ones1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
